tis_acc_unit: RTL and testbench
===============================

Name: tis_acc_unit

Overview:
Sequential execution unit for a TIS-100-style node: holds the ACC and BAK registers and executes one accumulator instruction per accepted request. It generalises the existing combinational ALU with a parametrised data width, optional saturating arithmetic, the SWP/SAV/MOV/CLR operations, and a valid/ready handshake with a registered result. It sits between the node's instruction decoder (upstream) and the port/jump logic (downstream), which consumes the result and flags.

Parameters:
N, 11, data width in bits, signed two's complement
SAT_EN, 1, 1 = clamp every ACC/BAK write to [-SAT_MAX, SAT_MAX]; 0 = wrap modulo 2^N
SAT_MAX, 999, saturation bound; must satisfy 0 < SAT_MAX <= 2^(N-1)-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request this cycle
op  input  3  operation code (see Behaviour)
operand  input  N  signed source value (ADD/SUB/MOV)
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream consumes the result this cycle
res  output  N  ACC value after the executed op
zero  output  1  res == 0
neg  output  1  res < 0

Behaviour:
- Reset (async, rst_n=0): ACC=0, BAK=0, res=0, zero=1, neg=0, out_valid=0. Takes effect mid-transaction; any held result is discarded.
- Handshake: in_ready = !out_valid || out_ready (combinational). A request is accepted when in_valid && in_ready. Inputs need not stay stable after acceptance.
- Latency: 1 cycle. On the edge that accepts a request, ACC/BAK update, res/zero/neg load the new ACC, and out_valid=1.
- If out_valid && out_ready and no request is accepted, out_valid clears to 0 on that edge; res and the flags hold their values.
- Back-to-back: when out_ready=1, one request per cycle, no bubbles.
- Stall: while out_valid && !out_ready, in_ready=0 and res, the flags, ACC and BAK hold.
- Op codes:
  - 000 NOP: no register change; still produces a result (res = ACC).
  - 001 ADD: ACC = f(ACC + operand).
  - 010 SUB: ACC = f(ACC - operand).
  - 011 NEG: ACC = f(-ACC).
  - 100 SWP: ACC <-> BAK, in the same edge.
  - 101 SAV: BAK = ACC.
  - 110 MOV: ACC = f(operand).
  - 111 CLR: ACC = 0, BAK unchanged.
- Arithmetic: sum and difference are computed in N+1 bits, sign-extended.
  - SAT_EN=1: f() clamps to [-SAT_MAX, SAT_MAX]. Examples: 999+1 -> 999; -999-5 -> -999; MOV 1500 -> 999.
  - SAT_EN=0: f() truncates to N bits (wrap). NEG of -2^(N-1) yields -2^(N-1).
- Flags are registered with res, so zero/neg always describe the current res.
- Invariant: with SAT_EN=1, |ACC| <= SAT_MAX and |BAK| <= SAT_MAX at all times.

Decomposition:
- Shared package tis_pkg:
  - op-code constants OP_NOP..OP_CLR (3-bit)
  - default width constant TIS_W=11
  - constant TIS_SAT=999
- One sub-module, tis_sat_clamp: a combinational N+1-bit to N-bit clamp, parametrised by N, SAT_EN and SAT_MAX. It is instantiated once on the ACC next-value path; SWP does not need it because BAK is already in range.

Test Plan:
- Reset mid-stall: out_valid=1, out_ready=0, drive rst_n=0 -> out_valid=0, res=0, zero=1 immediately, before the next clock edge.
- MOV 5, ADD 7, SUB 20 back-to-back with out_ready=1 -> res sequence 5, 12, -8 on consecutive cycles; the last has neg=1, zero=0; in_ready stays 1 throughout.
- SAT_EN=1: MOV 990, ADD 50, NEG, SUB 100 -> res 990, 999, -999, -999.
- SAT_EN=0, N=8: MOV 127, ADD 1 -> res -128; then NEG -> -128.
- MOV 3, SAV, MOV 9, SWP, SWP -> res 3, 3, 9, 3, 9; a final CLR -> res 0, zero=1.
- Backpressure: out_ready=0 for 4 cycles after ADD 1 with in_valid held high -> in_ready=0, res frozen at 1, ACC unchanged. When out_ready rises, the pending ADD 1 is accepted in that cycle and res=2 on the next edge.

Source files
------------

// File: rtl/tis_pkg.sv
// Shared definitions for the TIS-100 node accumulator unit:
// op-code encoding and default datapath width / saturation bound.
package tis_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_NEG = 3'b011,
    OP_SWP = 3'b100,
    OP_SAV = 3'b101,
    OP_MOV = 3'b110,
    OP_CLR = 3'b111
  } tis_op_e;

  localparam int TIS_W   = 11;
  localparam int TIS_SAT = 999;

endpackage

// File: rtl/tis_sat_clamp.sv
// Combinational N+1-bit to N-bit reduction: clamp to +/-SAT_MAX when
// saturation is enabled, otherwise two's-complement wrap to N bits.
module tis_sat_clamp
  import tis_pkg::*;
#(
  parameter int N       = TIS_W,
  parameter bit SAT_EN  = 1'b1,
  parameter int SAT_MAX = TIS_SAT
) (
  input  logic signed [N:0]   din,
  output logic signed [N-1:0] dout
);

  localparam logic signed [N:0] HI = (N+1)'(SAT_MAX);
  localparam logic signed [N:0] LO = -HI;

  function automatic logic signed [N-1:0] clamp_f(input logic signed [N:0] v);
    if (!SAT_EN) return v[N-1:0];
    if (v > HI)  return HI[N-1:0];
    if (v < LO)  return LO[N-1:0];
    return v[N-1:0];
  endfunction

  assign dout = clamp_f(din);

endmodule

// File: rtl/tis_acc_unit.sv
// TIS-100 node accumulator unit: ACC/BAK registers, one op per accepted
// request, registered result and flags behind a valid/ready handshake.
module tis_acc_unit
  import tis_pkg::*;
#(
  parameter int N       = TIS_W,
  parameter bit SAT_EN  = 1'b1,
  parameter int SAT_MAX = TIS_SAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic signed [N-1:0] operand,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] res,
  output logic                zero,
  output logic                neg
);

  logic signed [N-1:0] acc_q, acc_d;
  logic signed [N-1:0] bak_q, bak_d;
  logic signed [N-1:0] res_q, res_d;
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;
  logic                out_valid_q, out_valid_d;

  logic signed [N:0]   acc_x, opnd_x, arith_x;
  logic signed [N-1:0] arith_y;
  logic                accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Sign-extend by one bit so sums and differences cannot overflow before the clamp.
  assign acc_x  = {acc_q[N-1], acc_q};
  assign opnd_x = {operand[N-1], operand};

  always_comb begin
    arith_x = '0;
    case (tis_op_e'(op))
      OP_ADD:  arith_x = acc_x + opnd_x;
      OP_SUB:  arith_x = acc_x - opnd_x;
      OP_NEG:  arith_x = -acc_x;
      OP_MOV:  arith_x = opnd_x;
      default: arith_x = '0;
    endcase
  end

  tis_sat_clamp #(
    .N       (N),
    .SAT_EN  (SAT_EN),
    .SAT_MAX (SAT_MAX)
  ) u_clamp (
    .din  (arith_x),
    .dout (arith_y)
  );

  always_comb begin
    acc_d       = acc_q;
    bak_d       = bak_q;
    res_d       = res_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      case (tis_op_e'(op))
        OP_ADD, OP_SUB, OP_NEG, OP_MOV: acc_d = arith_y;
        // BAK is always in range, so the swap needs no clamp.
        OP_SWP: begin
          acc_d = bak_q;
          bak_d = acc_q;
        end
        OP_SAV:  bak_d = acc_q;
        OP_CLR:  acc_d = '0;
        default: acc_d = acc_q;
      endcase
      res_d       = acc_d;
      zero_d      = (acc_d == '0);
      neg_d       = acc_d[N-1];
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      bak_q       <= '0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      bak_q       <= bak_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign res       = res_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tis_acc_unit.sv
// Bench for tis_acc_unit: a saturating N=11 instance and a wrapping N=8
// instance, each checked every cycle against an integer reference model.
module tb_tis_acc_unit;
  import tis_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: N=11, saturating at +/-999
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, zero_a, neg_a;
  logic [2:0]  op_a;
  logic [10:0] operand_a, res_a;

  // Instance B: N=8, wrapping
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, zero_b, neg_b;
  logic [2:0]  op_b;
  logic [7:0]  operand_b, res_b;

  tis_acc_unit #(.N(11), .SAT_EN(1'b1), .SAT_MAX(999)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .op(op_a), .operand(operand_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .res(res_a), .zero(zero_a), .neg(neg_a));

  tis_acc_unit #(.N(8), .SAT_EN(1'b0), .SAT_MAX(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .op(op_b), .operand(operand_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .res(res_b), .zero(zero_b), .neg(neg_b));

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model on plain integers.
  function automatic int fix(input int v, input int n, input bit sat, input int smax);
    int m, r;
    if (sat) begin
      if (v > smax)  return smax;
      if (v < -smax) return -smax;
      return v;
    end
    m = 1 << n;
    r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic int m_acc(input logic [2:0] o, input int x, input int acc, input int bak,
                               input int n, input bit sat, input int smax);
    case (o)
      3'd1:    return fix(acc + x, n, sat, smax);
      3'd2:    return fix(acc - x, n, sat, smax);
      3'd3:    return fix(-acc, n, sat, smax);
      3'd4:    return bak;
      3'd6:    return fix(x, n, sat, smax);
      3'd7:    return 0;
      default: return acc;
    endcase
  endfunction

  function automatic int m_bak(input logic [2:0] o, input int acc, input int bak);
    if (o == 3'd4 || o == 3'd5) return acc;
    return bak;
  endfunction

  int ma_acc, ma_bak, ma_res; bit ma_vld;
  int mb_acc, mb_bak, mb_res; bit mb_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_acc <= 0; ma_bak <= 0; ma_res <= 0; ma_vld <= 1'b0;
    end else if (in_valid_a && (!ma_vld || out_ready_a)) begin
      ma_acc <= m_acc(op_a, int'($signed(operand_a)), ma_acc, ma_bak, 11, 1'b1, 999);
      ma_res <= m_acc(op_a, int'($signed(operand_a)), ma_acc, ma_bak, 11, 1'b1, 999);
      ma_bak <= m_bak(op_a, ma_acc, ma_bak);
      ma_vld <= 1'b1;
    end else if (ma_vld && out_ready_a) begin
      ma_vld <= 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_acc <= 0; mb_bak <= 0; mb_res <= 0; mb_vld <= 1'b0;
    end else if (in_valid_b && (!mb_vld || out_ready_b)) begin
      mb_acc <= m_acc(op_b, int'($signed(operand_b)), mb_acc, mb_bak, 8, 1'b0, 100);
      mb_res <= m_acc(op_b, int'($signed(operand_b)), mb_acc, mb_bak, 8, 1'b0, 100);
      mb_bak <= m_bak(op_b, mb_acc, mb_bak);
      mb_vld <= 1'b1;
    end else if (mb_vld && out_ready_b) begin
      mb_vld <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_out_valid", int'(out_valid_a), int'(ma_vld));
      check("a_in_ready",  int'(in_ready_a),  int'(!ma_vld || out_ready_a));
      check("a_res",       int'($signed(res_a)), ma_res);
      check("a_zero",      int'(zero_a), int'(ma_res == 0));
      check("a_neg",       int'(neg_a),  int'(ma_res < 0));
      check("b_out_valid", int'(out_valid_b), int'(mb_vld));
      check("b_in_ready",  int'(in_ready_b),  int'(!mb_vld || out_ready_b));
      check("b_res",       int'($signed(res_b)), mb_res);
      check("b_zero",      int'(zero_b), int'(mb_res == 0));
      check("b_neg",       int'(neg_b),  int'(mb_res < 0));
    end
  end

  // Drive one request (entered at +2 after an edge), expect acceptance, check res literally.
  task automatic step(input bit sel_b, input logic [2:0] o, input int v, input int exp, input string nm);
    if (!sel_b) begin
      in_valid_a = 1'b1; op_a = o; operand_a = v[10:0];
    end else begin
      in_valid_b = 1'b1; op_b = o; operand_b = v[7:0];
    end
    #1;
    check({nm, "_rdy"}, int'(sel_b ? in_ready_b : in_ready_a), 1);
    @(posedge clk); #1;
    check(nm, sel_b ? int'($signed(res_b)) : int'($signed(res_a)), exp);
    #1;
  endtask

  task automatic idle();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; op_a = 3'd0; operand_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; op_b = 3'd0; operand_b = '0; out_ready_b = 1'b1;
    @(posedge clk); #2;
    check("rst_res",   int'($signed(res_a)), 0);
    check("rst_zero",  int'(zero_a), 1);
    check("rst_neg",   int'(neg_a), 0);
    check("rst_valid", int'(out_valid_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Back-to-back MOV/ADD/SUB
    step(1'b0, OP_MOV, 5,  5,  "b2b_mov");
    step(1'b0, OP_ADD, 7,  12, "b2b_add");
    step(1'b0, OP_SUB, 20, -8, "b2b_sub");
    check("b2b_neg",  int'(neg_a), 1);
    check("b2b_zero", int'(zero_a), 0);
    idle();

    // Saturation
    step(1'b0, OP_MOV, 990,   990,  "sat_mov");
    step(1'b0, OP_ADD, 50,    999,  "sat_add");
    step(1'b0, OP_NEG, 0,     -999, "sat_neg");
    step(1'b0, OP_SUB, 100,   -999, "sat_sub");
    step(1'b0, OP_SUB, 5,     -999, "sat_sub5");
    step(1'b0, OP_MOV, 1023,  999,  "sat_movhi");
    step(1'b0, OP_MOV, -1024, -999, "sat_movlo");
    idle();

    // SAV / SWP / CLR
    step(1'b0, OP_MOV, 3, 3, "bak_mov3");
    step(1'b0, OP_SAV, 0, 3, "bak_sav");
    step(1'b0, OP_MOV, 9, 9, "bak_mov9");
    step(1'b0, OP_SWP, 0, 3, "bak_swp1");
    step(1'b0, OP_SWP, 0, 9, "bak_swp2");
    step(1'b0, OP_NOP, 0, 9, "bak_nop");
    step(1'b0, OP_CLR, 0, 0, "bak_clr");
    check("clr_zero", int'(zero_a), 1);
    idle();

    // Backpressure with the next request held
    out_ready_a = 1'b0;
    step(1'b0, OP_ADD, 1, 1, "bp_add");
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", int'(in_ready_a), 0);
      @(posedge clk); #1;
      check("bp_res_hold", int'($signed(res_a)), 1);
      #1;
    end
    out_ready_a = 1'b1;
    #1;
    check("bp_release_rdy", int'(in_ready_a), 1);
    @(posedge clk); #1;
    check("bp_release_res", int'($signed(res_a)), 2);
    #1;
    in_valid_a = 1'b0;

    // Asynchronous reset while a result is stalled
    out_ready_a = 1'b0;
    @(posedge clk); #2;
    check("stall_valid", int'(out_valid_a), 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid_a), 0);
    check("arst_res",   int'($signed(res_a)), 0);
    check("arst_zero",  int'(zero_a), 1);
    #1;
    rst_n = 1'b1;
    out_ready_a = 1'b1;
    @(posedge clk); #2;

    // Wrapping instance, N=8
    step(1'b1, OP_MOV, 127,  127,  "wrap_mov");
    step(1'b1, OP_ADD, 1,    -128, "wrap_add");
    step(1'b1, OP_NEG, 0,    -128, "wrap_neg");
    step(1'b1, OP_SUB, 1,    127,  "wrap_sub");
    step(1'b1, OP_MOV, -5,   -5,   "wrap_mov_neg");
    check("wrap_negflag", int'(neg_b), 1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
